nonce_dispatch: RTL and testbench

- Parametrised nonce scheduler between the processor and NUM_CORES parallel hash cores, generalising the single-core mining control.
- Splits the nonce space into interleaved strides: core i tries base+i, base+i+NUM_CORES, and so on.
- Tracks outstanding trials, captures the first winning nonce with fixed priority, and detects exhaustion of the nonce space.
- Hands the winning nonce to the UART send path over a req/ack handshake.

---
 rtl/nonce_dispatch_if.sv | 32 +++
 rtl/nonce_dispatch.sv | 145 ++++++++++++++
 tb/tb_nonce_dispatch.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/nonce_dispatch_if.sv
// rtl/nonce_dispatch_if.sv - processor, hash-core and send-path signals of the nonce dispatcher
interface nonce_dispatch_if #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32
);
    logic                           start;
    logic                           abort;
    logic [NONCE_W-1:0]             nonce_base;
    logic [NUM_CORES-1:0]           core_start;
    logic [NUM_CORES*NONCE_W-1:0]   core_nonce;
    logic [NUM_CORES-1:0]           core_valid;
    logic [NUM_CORES-1:0]           core_hit;
    logic                           busy;
    logic                           found;
    logic [NONCE_W-1:0]             found_nonce;
    logic                           exhausted;
    logic [NONCE_W:0]               tried_count;
    logic                           send_req;
    logic                           send_ack;

    modport slave (
        input  start, abort, nonce_base, core_valid, core_hit, send_ack,
        output core_start, core_nonce, busy, found, found_nonce, exhausted,
               tried_count, send_req
    );

    modport master (
        output start, abort, nonce_base, core_valid, core_hit, send_ack,
        input  core_start, core_nonce, busy, found, found_nonce, exhausted,
               tried_count, send_req
    );
endinterface

// File: rtl/nonce_dispatch.sv
// rtl/nonce_dispatch.sv - interleaved-stride nonce scheduler for NUM_CORES hash cores
module nonce_dispatch #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    nonce_dispatch_if.slave     bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, RUN, REPORT, DONE} state_t;

    // Cores beyond the size of the nonce space never receive work.
    localparam int ACTIVE = (NONCE_W >= 5) ? NUM_CORES :
                            ((NUM_CORES < (1 << NONCE_W)) ? NUM_CORES : (1 << NONCE_W));
    localparam logic [NUM_CORES-1:0] ACTIVE_MASK = NUM_CORES'((32'd1 << ACTIVE) - 32'd1);
    localparam logic [NONCE_W:0]     SPACE       = {1'b1, {NONCE_W{1'b0}}};
    localparam logic [NONCE_W:0]     ISSUE_INIT  = (NONCE_W+1)'(ACTIVE);
    localparam logic [NONCE_W:0]     ONE         = (NONCE_W+1)'(1);
    localparam logic [NONCE_W-1:0]   STRIDE      = NONCE_W'(NUM_CORES);

    state_t                              state_q;
    logic [NUM_CORES-1:0][NONCE_W-1:0]   nonce_q;
    logic [NUM_CORES-1:0]                outstanding_q;
    logic [NUM_CORES-1:0]                core_start_q;
    logic [NONCE_W:0]                    issued_q;
    logic [NONCE_W:0]                    tried_q;
    logic                                found_q, exhausted_q, send_req_q, busy_q;
    logic [NONCE_W-1:0]                  found_nonce_q;

    logic [NUM_CORES-1:0]                acc, hit, start_d, outstanding_d;
    logic [NUM_CORES-1:0][NONCE_W-1:0]   nonce_d;
    logic [NONCE_W:0]                    issued_d, tried_d;
    logic [NONCE_W-1:0]                  win_nonce;
    logic                                exhaust;

    // RUN datapath: lower core index claims the lower issued slot.
    always_comb begin
        acc       = bus.core_valid & outstanding_q;
        hit       = acc & bus.core_hit;
        nonce_d   = nonce_q;
        issued_d  = issued_q;
        tried_d   = tried_q;
        start_d   = '0;
        win_nonce = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (acc[i]) begin
                tried_d = tried_d + ONE;
                if (issued_d < SPACE) begin
                    nonce_d[i] = nonce_q[i] + STRIDE;
                    issued_d   = issued_d + ONE;
                    start_d[i] = 1'b1;
                end
            end
        end
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit[i]) win_nonce = nonce_q[i];
        end
        outstanding_d = (outstanding_q & ~acc) | start_d;
        exhaust       = (issued_d == SPACE) && (outstanding_d == '0);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= IDLE;
            nonce_q       <= '0;
            outstanding_q <= '0;
            core_start_q  <= '0;
            issued_q      <= '0;
            tried_q       <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            send_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            found_nonce_q <= '0;
        end else if (bus.abort) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            core_start_q  <= '0;
            tried_q       <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            send_req_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            core_start_q <= '0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        for (int i = 0; i < NUM_CORES; i++) begin
                            nonce_q[i] <= bus.nonce_base + NONCE_W'(i);
                        end
                        found_q     <= 1'b0;
                        exhausted_q <= 1'b0;
                        tried_q     <= '0;
                        issued_q    <= ISSUE_INIT;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_start_q  <= ACTIVE_MASK;
                    outstanding_q <= ACTIVE_MASK;
                    state_q       <= RUN;
                end
                RUN: begin
                    tried_q <= tried_d;
                    if (hit != '0) begin
                        found_q       <= 1'b1;
                        found_nonce_q <= win_nonce;
                        send_req_q    <= 1'b1;
                        outstanding_q <= '0;
                        state_q       <= REPORT;
                    end else begin
                        nonce_q       <= nonce_d;
                        issued_q      <= issued_d;
                        core_start_q  <= start_d;
                        outstanding_q <= outstanding_d;
                        if (exhaust) begin
                            exhausted_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= DONE;
                        end
                    end
                end
                REPORT: begin
                    if (bus.send_ack && send_req_q) begin
                        send_req_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.core_start  = core_start_q;
    assign bus.core_nonce  = nonce_q;
    assign bus.busy        = busy_q;
    assign bus.found       = found_q;
    assign bus.found_nonce = found_nonce_q;
    assign bus.exhausted   = exhausted_q;
    assign bus.tried_count = tried_q;
    assign bus.send_req    = send_req_q;
endmodule

// File: tb/tb_nonce_dispatch.sv
// tb/tb_nonce_dispatch.sv - directed bench for nonce_dispatch (8-bit and 4-bit nonce spaces)
module tb_nonce_dispatch;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nonce_dispatch_if #(.NUM_CORES(4), .NONCE_W(8)) a_if ();
    nonce_dispatch_if #(.NUM_CORES(4), .NONCE_W(4)) b_if ();

    nonce_dispatch #(.NUM_CORES(4), .NONCE_W(8)) u_a (
        .clock_i (clk), .reset_ni(rst_n), .bus(a_if.slave));
    nonce_dispatch #(.NUM_CORES(4), .NONCE_W(4)) u_b (
        .clock_i (clk), .reset_ni(rst_n), .bus(b_if.slave));

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_nonce;

    logic [15:0] seen = '0;
    int          b_starts = 0;
    int          b_dups = 0;
    logic [3:0]  pipe1 = '0, pipe2 = '0;
    int          wait_cycles;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model of four hash cores on the 4-bit instance: answer 2 cycles after issue, never hit.
    initial begin
        b_if.core_valid = '0;
        b_if.core_hit   = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (b_if.core_start[i]) begin
                    if (seen[b_if.core_nonce[i*4 +: 4]]) b_dups++;
                    seen[b_if.core_nonce[i*4 +: 4]] = 1'b1;
                    b_starts++;
                end
            end
            b_if.core_valid = pipe2;
            pipe2 = pipe1;
            pipe1 = b_if.core_start;
        end
    end

    initial begin
        rst_n = 1'b0;
        a_if.start = 0; a_if.abort = 0; a_if.nonce_base = '0;
        a_if.core_valid = '0; a_if.core_hit = '0; a_if.send_ack = 0;
        b_if.start = 0; b_if.abort = 0; b_if.nonce_base = '0; b_if.send_ack = 0;
        tick(); tick();
        chk("rst_busy", a_if.busy, 0);
        chk("rst_core_nonce", a_if.core_nonce, 0);
        chk("rst_tried", a_if.tried_count, 0);
        chk("rst_found", a_if.found, 0);
        chk("rst_send_req", a_if.send_req, 0);
        chk("rst_core_start", a_if.core_start, 0);
        rst_n = 1'b1;

        // Job at FE: nonces wrap across the top of the space.
        tick(); a_if.nonce_base = 8'hFE; a_if.start = 1;
        tick(); a_if.start = 0;
        chk("issue_busy", a_if.busy, 1);
        chk("issue_nonces", a_if.core_nonce, 32'h0100FFFE);
        chk("issue_no_start_yet", a_if.core_start, 0);
        tick();
        chk("first_core_start", a_if.core_start, 4'b1111);
        a_if.start = 1; a_if.nonce_base = 8'h55;
        tick(); a_if.start = 0;
        chk("start_busy_ignored", a_if.core_nonce, 32'h0100FFFE);
        chk("no_start_pulse", a_if.core_start, 0);
        a_if.core_valid = 4'b0001;
        tick(); a_if.core_valid = '0;
        chk("reissue_start", a_if.core_start, 4'b0001);
        chk("reissue_nonce", a_if.core_nonce, 32'h0100FF02);
        chk("reissue_tried", a_if.tried_count, 1);

        // Abort mid-run, then late results and start+abort collisions.
        a_if.abort = 1;
        tick(); a_if.abort = 0;
        chk("abort_busy", a_if.busy, 0);
        chk("abort_tried", a_if.tried_count, 0);
        chk("abort_found", a_if.found, 0);
        chk("abort_core_start", a_if.core_start, 0);
        a_if.core_valid = 4'b1111; a_if.core_hit = 4'b1111;
        tick(); a_if.core_valid = '0; a_if.core_hit = '0;
        chk("late_valid_tried", a_if.tried_count, 0);
        chk("late_valid_found", a_if.found, 0);
        chk("late_valid_send_req", a_if.send_req, 0);
        a_if.start = 1; a_if.abort = 1;
        tick(); a_if.start = 0; a_if.abort = 0;
        chk("start_abort_busy", a_if.busy, 0);
        tick();
        chk("start_abort_no_issue", a_if.core_start, 0);

        // Simultaneous hits: lowest index wins.
        a_if.nonce_base = 8'h10; a_if.start = 1;
        tick(); a_if.start = 0;
        tick();
        chk("hit_job_start", a_if.core_start, 4'b1111);
        a_if.core_valid = 4'b0110; a_if.core_hit = 4'b0110;
        exp_q.push_back(8'h11);
        tick(); a_if.core_valid = '0; a_if.core_hit = '0;
        chk("hit_found", a_if.found, 1);
        chk("hit_send_req", a_if.send_req, 1);
        chk("hit_tried", a_if.tried_count, 2);
        if (a_if.send_req && exp_q.size() > 0) begin
            exp_nonce = exp_q.pop_front();
            chk("hit_found_nonce", a_if.found_nonce, exp_nonce);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_send_req", a_if.send_req, 1);
            chk("hold_found_nonce", a_if.found_nonce, 8'h11);
        end
        a_if.send_ack = 1;
        tick(); a_if.send_ack = 0;
        chk("ack_send_req", a_if.send_req, 0);
        chk("ack_busy", a_if.busy, 0);
        chk("done_found", a_if.found, 1);
        a_if.send_ack = 1;
        tick(); a_if.send_ack = 0;
        chk("stray_ack_found_nonce", a_if.found_nonce, 8'h11);
        chk("stray_ack_busy", a_if.busy, 0);

        // Restart from DONE, hit on core 3, then async reset while reporting.
        a_if.nonce_base = 8'h20; a_if.start = 1;
        tick(); a_if.start = 0;
        chk("restart_clears_found", a_if.found, 0);
        tick();
        a_if.core_valid = 4'b1000; a_if.core_hit = 4'b1000;
        exp_q.push_back(8'h23);
        tick(); a_if.core_valid = '0; a_if.core_hit = '0;
        chk("report_send_req", a_if.send_req, 1);
        if (a_if.send_req && exp_q.size() > 0) begin
            exp_nonce = exp_q.pop_front();
            chk("core3_found_nonce", a_if.found_nonce, exp_nonce);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_send_req", a_if.send_req, 0);
        chk("async_rst_found", a_if.found, 0);
        chk("async_rst_found_nonce", a_if.found_nonce, 0);
        chk("async_rst_busy", a_if.busy, 0);
        chk("async_rst_core_nonce", a_if.core_nonce, 0);
        tick(); rst_n = 1'b1;
        chk("scoreboard_empty", exp_q.size(), 0);

        // Exhaustion of a 16-value space, base wraps at 9.
        tick(); b_if.nonce_base = 4'h9; b_if.start = 1;
        tick(); b_if.start = 0;
        wait_cycles = 0;
        while (!b_if.exhausted && wait_cycles < 200) begin
            tick();
            wait_cycles++;
        end
        chk("exh_flag", b_if.exhausted, 1);
        chk("exh_tried", b_if.tried_count, 16);
        chk("exh_found", b_if.found, 0);
        chk("exh_busy", b_if.busy, 0);
        tick(); tick(); tick();
        chk("exh_start_count", b_starts, 16);
        chk("exh_all_nonces", seen, 16'hFFFF);
        chk("exh_no_dups", b_dups, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
